sal_bk_ctrl: RTL and testbench
==============================

// Module: sal_bk_ctrl
// PURPOSE
//  Per-bank DDR2 command requester; the bank-side end of the bank/scheduler req/gnt handshake.
//  Tracks the bank's open row and turns upstream read/write requests into ACT/RD/WR/PRE requests.
//  Also issues REF requests and enforces per-bank timing (tRCD, tRAS, tRP, tRFC, tRTP, tWR).
//  One instance per bank (`DRAM_BK_CNT); outputs connect to the BK_SCHED_IF bank-side signals.
// PARAMETERS
//  ROW_AW   14  row address width
//  TIMER_W   6  width of every timing counter; must hold the largest T_*
//  T_RCD     3  cycles from ACT grant to the first RD/WR request
//  T_RAS     8  cycles from ACT grant to a PRE request
//  T_RP      3  cycles from PRE grant to an ACT/REF request
//  T_RFC    26  cycles from REF grant to an ACT/REF request
//  T_RTP     2  cycles from RD grant to a PRE request
//  T_WTP     8  cycles from WR grant to a PRE request (WL+BL/2+tWR)
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous, active-high reset
//  req_valid    in   1       upstream request present; held stable until req_ready
//  req_wr       in   1       1=write, 0=read
//  req_row      in   ROW_AW  target row
//  req_ready    out  1       request consumed this cycle (RD/WR granted)
//  ref_pending  in   1       refresh owed (level, from the refresh timer)
//  ref_done     out  1       1-cycle pulse when tRFC expires
//  act_req/act_gnt, rd_req/rd_gnt, wr_req/wr_gnt, pre_req/pre_gnt, ref_req/ref_gnt
//               out/in 1     bank->scheduler request / scheduler->bank grant
//  act_row      out  ROW_AW  row for the pending ACT (= req_row)
//  bank_open    out  1       a row is open
//  open_row     out  ROW_AW  currently open row
// BEHAVIOUR
//  Reset: state CLOSED; all *_req, req_ready, ref_done, bank_open = 0; open_row = 0; all timers = 0.
//   The bank is treated as precharged after reset. A reset mid-operation abandons any pending request.
//  Reset rule: act_row is combinational from req_row in every state, including reset.
//  Handshake:
//   - At most one *_req is high in a cycle, and it is computed combinationally from state, timers and inputs.
//   - A command counts as issued only on the cycle where req & gnt are both high; gnt may arrive the same cycle as req.
//   - A gnt without its req is ignored.
//   - A req may drop without a gnt if its inputs change (e.g. ref_pending rises).
//  Timers: a countdown is loaded with T-1 on the grant cycle; a gated request is allowed only when the counter is 0.
//   So the minimum spacing from grant to the next dependent grant is T cycles.
//  States:
//   - CLOSED:
//     - ref_pending & tRP/tRFC done -> ref_req. ref_gnt -> REFRESH.
//     - else req_valid & tRP/tRFC done -> act_req. act_gnt -> OPEN; open_row <= req_row; load tRCD and tRAS.
//   - OPEN (bank_open=1):
//     - ref_pending -> pre_req once tRAS, tRTP and tWTP are all 0.
//     - else if req_valid & req_row==open_row & tRCD done -> rd_req or wr_req.
//       A grant pulses req_ready the same cycle and loads tRTP (RD) or tWTP (WR).
//     - else if req_valid & row miss -> pre_req under the same gating as the refresh case.
//     - pre_gnt -> PRECHARGE; load tRP; bank_open <= 0.
//     - Idle: the row stays open (open-page policy).
//   - PRECHARGE: once tRP reaches 0 -> CLOSED. Re-enters CLOSED in the same cycle the counter reaches 0.
//   - REFRESH: tRFC counts down; at 0 -> CLOSED with ref_done=1 for exactly that cycle.
//  Priority: refresh beats new requests in both CLOSED and OPEN. A row hit never precharges.
//  Row compare uses the full ROW_AW bits; counters saturate at 0 (no wrap).
//  Back-to-back hits: a new RD/WR can be requested the cycle after req_ready.
// STRUCTURE
//  SAL_DDR2_PARAMS.svh: T_* defaults and ROW_AW.
//  Shared package sal_bk_pkg: bk_state_t enum {CLOSED, OPEN, PRECHARGE, REFRESH}.
//  Sub-module sal_bk_timer: a TIMER_W load/countdown counter with a 'zero' output.
//   Instances: tRCD, tRAS, tRP/tRFC (shared), tRTP/tWTP (shared; load the max of the new and current values).
// TESTING
//  1. Closed, RD row 5, gnt tied to req: ACT@0, RD@3, req_ready@3; open_row=5.
//  2. Open row 5, RD row 9, grants immediate: PRE at cycle max(tRAS,tRTP) after ACT; ACT row 9 T_RP later; RD T_RCD later.
//  3. Open row 5, WR hit then RD row 9: PRE no earlier than 8 cycles after the WR grant.
//  4. ref_pending and req_valid both rise in CLOSED:
//     - ref_req first; ref_done 26 cycles after ref_gnt; then ACT.
//  5. Scheduler withholds act_gnt for 10 cycles: act_req stays high and stable; no other req; the state holds.
//  6. rst during REFRESH and during OPEN: next cycle all req low, bank_open=0, CLOSED; a fresh request gets ACT immediately.

Source files
------------

// File: rtl/sal_bk_pkg.sv
// Shared definitions for the per-bank DDR2 command requester:
// default geometry and timing values, and the bank state encoding.
package sal_bk_pkg;

  localparam int ROW_AW_DEF  = 14;
  localparam int TIMER_W_DEF = 6;

  localparam int T_RCD_DEF = 3;
  localparam int T_RAS_DEF = 8;
  localparam int T_RP_DEF  = 3;
  localparam int T_RFC_DEF = 26;
  localparam int T_RTP_DEF = 2;
  localparam int T_WTP_DEF = 8;

  typedef enum logic [1:0] {
    CLOSED    = 2'd0,
    OPEN      = 2'd1,
    PRECHARGE = 2'd2,
    REFRESH   = 2'd3
  } bk_state_t;

endpackage

// File: rtl/sal_bk_ctrl_if.sv
// Bank-side signal bundle: upstream read/write request, refresh
// handshake and the req/gnt pairs towards the bank scheduler.
// master = bank controller, slave = upstream + scheduler side.
interface sal_bk_ctrl_if
  import sal_bk_pkg::*;
#(
  parameter int ROW_AW = ROW_AW_DEF
);

  logic              req_valid;
  logic              req_wr;
  logic [ROW_AW-1:0] req_row;
  logic              req_ready;

  logic              ref_pending;
  logic              ref_done;

  logic              act_req, act_gnt;
  logic              rd_req,  rd_gnt;
  logic              wr_req,  wr_gnt;
  logic              pre_req, pre_gnt;
  logic              ref_req, ref_gnt;

  logic [ROW_AW-1:0] act_row;
  logic              bank_open;
  logic [ROW_AW-1:0] open_row;

  modport master (
    input  req_valid, req_wr, req_row, ref_pending,
    input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
    output req_ready, ref_done,
    output act_req, rd_req, wr_req, pre_req, ref_req,
    output act_row, bank_open, open_row
  );

  modport slave (
    output req_valid, req_wr, req_row, ref_pending,
    output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
    input  req_ready, ref_done,
    input  act_req, rd_req, wr_req, pre_req, ref_req,
    input  act_row, bank_open, open_row
  );

endinterface

// File: rtl/sal_bk_timer.sv
// Load/countdown timer. Loaded with T-1 on a grant, it reaches zero
// exactly T cycles later and then holds at zero. With MAX_LOAD set,
// a new load never shortens a deadline that is already running.
module sal_bk_timer
  import sal_bk_pkg::*;
#(
  parameter int W        = TIMER_W_DEF,
  parameter bit MAX_LOAD = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_dec;

  assign cnt_dec = (cnt == '0) ? '0 : cnt - W'(1);

  // Countdown register: load takes precedence, otherwise saturating decrement.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (MAX_LOAD && (cnt_dec > load_val)) ? cnt_dec : load_val;
    end else begin
      cnt <= cnt_dec;
    end
  end

endmodule

// File: rtl/sal_bk_ctrl.sv
// Per-bank DDR2 command requester. Tracks the open row, turns upstream
// read/write requests into ACT/RD/WR/PRE requests, issues REF when a
// refresh is owed, and holds every request off until its timing
// constraint has elapsed. A command is issued on a req & gnt cycle.
module sal_bk_ctrl
  import sal_bk_pkg::*;
#(
  parameter int ROW_AW  = ROW_AW_DEF,
  parameter int TIMER_W = TIMER_W_DEF,
  parameter int T_RCD   = T_RCD_DEF,
  parameter int T_RAS   = T_RAS_DEF,
  parameter int T_RP    = T_RP_DEF,
  parameter int T_RFC   = T_RFC_DEF,
  parameter int T_RTP   = T_RTP_DEF,
  parameter int T_WTP   = T_WTP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  sal_bk_ctrl_if.master bus
);

  localparam logic [TIMER_W-1:0] RCD_LD = TIMER_W'(T_RCD - 1);
  localparam logic [TIMER_W-1:0] RAS_LD = TIMER_W'(T_RAS - 1);
  localparam logic [TIMER_W-1:0] RP_LD  = TIMER_W'(T_RP - 1);
  localparam logic [TIMER_W-1:0] RFC_LD = TIMER_W'(T_RFC - 1);
  localparam logic [TIMER_W-1:0] RTP_LD = TIMER_W'(T_RTP - 1);
  localparam logic [TIMER_W-1:0] WTP_LD = TIMER_W'(T_WTP - 1);

  bk_state_t         state, state_nxt;
  logic [ROW_AW-1:0] open_row;
  logic              ref_done_q, ref_done_nxt;

  logic act_req, rd_req, wr_req, pre_req, ref_req;
  logic act_go, rd_go, wr_go, pre_go, ref_go;

  logic [TIMER_W-1:0] rcd_cnt, ras_cnt, rp_cnt, rtp_cnt;
  logic               row_hit, pre_ok, rp_last;

  assign act_go = act_req & bus.act_gnt;
  assign rd_go  = rd_req  & bus.rd_gnt;
  assign wr_go  = wr_req  & bus.wr_gnt;
  assign pre_go = pre_req & bus.pre_gnt;
  assign ref_go = ref_req & bus.ref_gnt;

  // ACT -> RD/WR spacing
  sal_bk_timer #(.W(TIMER_W)) u_rcd (
    .clk(clk), .rst(rst), .load(act_go), .load_val(RCD_LD), .cnt(rcd_cnt)
  );

  // ACT -> PRE spacing
  sal_bk_timer #(.W(TIMER_W)) u_ras (
    .clk(clk), .rst(rst), .load(act_go), .load_val(RAS_LD), .cnt(ras_cnt)
  );

  // PRE -> ACT/REF and REF -> ACT/REF spacing share one counter
  sal_bk_timer #(.W(TIMER_W)) u_rp (
    .clk(clk), .rst(rst), .load(pre_go | ref_go),
    .load_val(ref_go ? RFC_LD : RP_LD), .cnt(rp_cnt)
  );

  // RD -> PRE and WR -> PRE spacing; the later deadline wins
  sal_bk_timer #(.W(TIMER_W), .MAX_LOAD(1'b1)) u_rtp (
    .clk(clk), .rst(rst), .load(rd_go | wr_go),
    .load_val(wr_go ? WTP_LD : RTP_LD), .cnt(rtp_cnt)
  );

  assign row_hit = (bus.req_row == open_row);
  assign pre_ok  = (ras_cnt == '0) && (rtp_cnt == '0);
  // The shared counter hits zero on the next edge: leave PRECHARGE/REFRESH on that edge.
  assign rp_last = (rp_cnt <= TIMER_W'(1));

  // Request selection and next state; refresh outranks new work, a hit never precharges.
  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    ref_done_nxt = 1'b0;
    act_req      = 1'b0;
    rd_req       = 1'b0;
    wr_req       = 1'b0;
    pre_req      = 1'b0;
    ref_req      = 1'b0;

    unique case (state)
      CLOSED: begin
        if (bus.ref_pending) begin
          ref_req = (rp_cnt == '0);
          if (ref_req && bus.ref_gnt) state_nxt = REFRESH;
        end else if (bus.req_valid) begin
          act_req = (rp_cnt == '0);
          if (act_req && bus.act_gnt) state_nxt = OPEN;
        end
      end
      OPEN: begin
        if (bus.ref_pending) begin
          pre_req = pre_ok;
        end else if (bus.req_valid && row_hit) begin
          rd_req = (rcd_cnt == '0) && !bus.req_wr;
          wr_req = (rcd_cnt == '0) &&  bus.req_wr;
        end else if (bus.req_valid) begin
          pre_req = pre_ok;
        end
        if (pre_req && bus.pre_gnt) state_nxt = PRECHARGE;
      end
      PRECHARGE: begin
        if (rp_last) state_nxt = CLOSED;
      end
      REFRESH: begin
        if (rp_last) begin
          state_nxt    = CLOSED;
          ref_done_nxt = 1'b1;
        end
      end
    endcase

    // A bank held in reset requests nothing.
    if (rst) begin
      act_req = 1'b0;
      rd_req  = 1'b0;
      wr_req  = 1'b0;
      pre_req = 1'b0;
      ref_req = 1'b0;
    end
  end

  // State, open row and the refresh-complete pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLOSED;
      open_row   <= '0;
      ref_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      ref_done_q <= ref_done_nxt;
      if (act_go) open_row <= bus.req_row;
    end
  end

  assign bus.act_req   = act_req;
  assign bus.rd_req    = rd_req;
  assign bus.wr_req    = wr_req;
  assign bus.pre_req   = pre_req;
  assign bus.ref_req   = ref_req;
  assign bus.req_ready = rd_go | wr_go;
  assign bus.ref_done  = ref_done_q;
  assign bus.act_row   = bus.req_row;
  assign bus.bank_open = (state == OPEN);
  assign bus.open_row  = open_row;

endmodule

// File: tb/tb_sal_bk_ctrl.sv
// Bench for sal_bk_ctrl. The reference model keeps absolute grant times
// per command type and derives each cycle's legal request from the
// timing rules (earliest cycle = last grant + T), independent of any
// state encoding. Directed scenarios first, then randomized traffic.
module tb_sal_bk_ctrl;
  import sal_bk_pkg::*;

  localparam int T_RCD = 3;
  localparam int T_RAS = 8;
  localparam int T_RP  = 3;
  localparam int T_RFC = 26;
  localparam int T_RTP = 2;
  localparam int T_WTP = 8;
  localparam int NEVER = -1000;

  localparam logic [13:0] ROWS [5] = '{14'd5, 14'd9, 14'h2005, 14'h0000, 14'h3fff};

  typedef struct packed {
    logic act;
    logic rd;
    logic wr;
    logic pre;
    logic rf;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sal_bk_ctrl_if #(.ROW_AW(14)) bus ();

  sal_bk_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // upstream / refresh stimulus and grant policy (0 tied, 1 random, 2 withhold)
  logic        d_valid = 1'b0;
  logic        d_wr    = 1'b0;
  logic        d_ref   = 1'b0;
  logic [13:0] d_row   = '0;
  int          gnt_mode = 0;
  bit          just_reset = 1'b0;

  // reference model: open row and last grant time of each command type
  bit          m_open;
  logic [13:0] m_row;
  int          t_act, t_pre, t_ref, t_rd, t_wr;

  // DUT-observed event cycles for the directed latency checks
  int o_act, o_rd, o_wr, o_pre, o_ref, o_done, act_hi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t model_req();
    cmd_t r;
    bit   closed_ok;
    bit   pre_ok;
    r         = '0;
    closed_ok = (cyc >= t_pre + T_RP) && (cyc >= t_ref + T_RFC);
    pre_ok    = (cyc >= t_act + T_RAS) && (cyc >= t_rd + T_RTP) && (cyc >= t_wr + T_WTP);
    if (!m_open) begin
      if (d_ref)        r.rf  = closed_ok;
      else if (d_valid) r.act = closed_ok;
    end else if (d_ref) begin
      r.pre = pre_ok;
    end else if (d_valid && d_row == m_row) begin
      if (cyc >= t_act + T_RCD) begin
        r.wr = d_wr;
        r.rd = !d_wr;
      end
    end else if (d_valid) begin
      r.pre = pre_ok;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_open = 1'b0;
    m_row  = '0;
    t_act  = NEVER;
    t_pre  = NEVER;
    t_ref  = NEVER;
    t_rd   = NEVER;
    t_wr   = NEVER;
  endtask

  task automatic clr_obs();
    o_act  = NEVER;
    o_rd   = NEVER;
    o_wr   = NEVER;
    o_pre  = NEVER;
    o_ref  = NEVER;
    o_done = NEVER;
    act_hi = 0;
  endtask

  task automatic drive_gnt(input cmd_t g);
    bus.act_gnt = g.act;
    bus.rd_gnt  = g.rd;
    bus.wr_gnt  = g.wr;
    bus.pre_gnt = g.pre;
    bus.ref_gnt = g.rf;
  endtask

  // One clock: drive at negedge, check 1ns later, advance model at posedge.
  task automatic step();
    cmd_t       e;
    cmd_t       g;
    cmd_t       iss;
    logic [4:0] rv;
    @(negedge clk);
    rst             = 1'b0;
    bus.req_valid   = d_valid;
    bus.req_wr      = d_wr;
    bus.req_row     = d_row;
    bus.ref_pending = d_ref;
    e = model_req();
    case (gnt_mode)
      0:       g = e;
      1:       begin rv = 5'($urandom); g = rv; end
      default: g = '0;
    endcase
    drive_gnt(g);
    #1;
    check($sformatf("cmd_req@%0d", cyc),
          {27'd0, bus.act_req, bus.rd_req, bus.wr_req, bus.pre_req, bus.ref_req},
          {27'd0, e});
    check($sformatf("ready_done_open@%0d", cyc),
          {29'd0, bus.req_ready, bus.ref_done, bus.bank_open},
          {29'd0, (e.rd & g.rd) | (e.wr & g.wr), cyc == t_ref + T_RFC, m_open});
    check($sformatf("act_row@%0d", cyc), {18'd0, bus.act_row}, {18'd0, d_row});
    if (m_open) check($sformatf("open_row@%0d", cyc), {18'd0, bus.open_row}, {18'd0, m_row});
    if (just_reset) begin
      check("reset_open_row", {18'd0, bus.open_row}, 32'd0);
      just_reset = 1'b0;
    end
    if (bus.act_req && bus.act_gnt) o_act = cyc;
    if (bus.rd_req  && bus.rd_gnt)  o_rd  = cyc;
    if (bus.wr_req  && bus.wr_gnt)  o_wr  = cyc;
    if (bus.pre_req && bus.pre_gnt) o_pre = cyc;
    if (bus.ref_req && bus.ref_gnt) o_ref = cyc;
    if (bus.ref_done)               o_done = cyc;
    if (bus.act_req)                act_hi++;
    @(posedge clk);
    iss = e & g;
    if (iss.act) begin m_open = 1'b1; m_row = d_row; t_act = cyc; end
    if (iss.pre) begin m_open = 1'b0; t_pre = cyc; end
    if (iss.rf)  t_ref = cyc;
    if (iss.rd)  t_rd  = cyc;
    if (iss.wr)  t_wr  = cyc;
    if (iss.rd || iss.wr) d_valid = 1'b0;
    if (iss.rf) d_ref = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    d_valid         = 1'b0;
    d_ref           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_wr      = 1'b0;
    bus.req_row     = '0;
    bus.ref_pending = 1'b0;
    drive_gnt('0);
    @(posedge clk);
    model_reset();
    just_reset = 1'b1;
    cyc++;
  endtask

  task automatic run_until_idle(input string tag, input int bound);
    for (int i = 0; i < bound && (d_valid || d_ref); i++) step();
    check({tag, "_drained"}, {30'd0, d_valid, d_ref}, 32'd0);
  endtask

  task automatic request(input logic wr, input logic [13:0] row);
    d_valid = 1'b1;
    d_wr    = wr;
    d_row   = row;
  endtask

  initial begin
    int c0;
    int a1;
    model_reset();
    clr_obs();

    // 1: closed bank, RD row 5, grants tied to requests
    do_reset();
    clr_obs();
    gnt_mode = 0;
    step();
    c0 = cyc;
    request(1'b0, 14'd5);
    run_until_idle("t1", 20);
    check("t1_act_at_0", o_act - c0, 0);
    check("t1_rd_at_3", o_rd - o_act, 3);

    // 2: row miss to row 9 from open row 5
    a1 = o_act;
    request(1'b0, 14'd9);
    run_until_idle("t2", 40);
    check("t2_pre_after_act", o_pre - a1, 8);
    check("t2_act_after_pre", o_act - o_pre, 3);
    check("t2_rd_after_act", o_rd - o_act, 3);

    // 3: WR hit back-to-back after RD, then a miss waits out write-to-precharge
    do_reset();
    clr_obs();
    request(1'b0, 14'd5);
    run_until_idle("t3a", 20);
    request(1'b1, 14'd5);
    run_until_idle("t3b", 20);
    check("t3_wr_back_to_back", o_wr - o_rd, 1);
    request(1'b0, 14'd9);
    run_until_idle("t3c", 40);
    check("t3_pre_after_wr", o_pre - o_wr, 8);

    // 4: refresh and request together in CLOSED; refresh wins
    do_reset();
    clr_obs();
    c0 = cyc;
    d_ref = 1'b1;
    request(1'b0, 14'd7);
    run_until_idle("t4", 60);
    check("t4_ref_first", o_ref - c0, 0);
    check("t4_ref_done", o_done - o_ref, 26);
    check("t4_act_after_ref", o_act - o_ref, 26);

    // 5: scheduler withholds grants for 10 cycles
    do_reset();
    clr_obs();
    gnt_mode = 2;
    request(1'b0, 14'd3);
    repeat (10) step();
    check("t5_act_held", act_hi, 10);
    check("t5_no_grant", o_act, NEVER);
    gnt_mode = 0;
    c0 = cyc;
    run_until_idle("t5", 20);
    check("t5_act_on_grant", o_act, c0);

    // 6a: reset in the middle of a refresh
    do_reset();
    clr_obs();
    d_ref = 1'b1;
    repeat (5) step();
    check("t6_in_refresh", o_ref >= 0, 1);
    do_reset();
    step();
    request(1'b0, 14'd4);
    c0 = cyc;
    step();
    check("t6a_act_immediate", o_act, c0);
    run_until_idle("t6a", 20);

    // 6b: reset with a row open
    do_reset();
    step();
    request(1'b1, 14'd11);
    c0 = cyc;
    step();
    check("t6b_act_immediate", o_act, c0);
    run_until_idle("t6b", 20);

    // randomized traffic with random grants
    do_reset();
    gnt_mode = 1;
    repeat (3000) begin
      if (!d_valid && $urandom_range(2, 0) == 0)
        request(1'($urandom), ROWS[$urandom_range(4, 0)]);
      if (!d_ref && $urandom_range(59, 0) == 0) d_ref = 1'b1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
